// File: rtl/demux_two.sv
// Receiving end of a two-channel bus: Y words steered by S, gated by active-low E,
// into per-channel circular buffers. Optional DROPS counter via DEMUX_TWO_DROP_CNT_EN.

module demux_two_chan #(
  parameter int W     = 4,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] data,
  input  logic         rdy,
  output logic [W-1:0] head,
  output logic         valid,
  output logic         full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PART  = 2'd1,
    ST_FULL  = 2'd2
  } chan_state_t;

  chan_state_t   state_r;
  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [W-1:0]  head_r;

  logic          pop_s;
  logic [AW-1:0] wr_next_s;
  logic [AW-1:0] rd_next_s;
  logic [AW:0]   cnt_next_s;
  logic [W-1:0]  head_next_s;

  // Next pointers, count and head word; pop is only honoured when a word is held.
  always_comb begin
    pop_s       = 1'b0;
    wr_next_s   = wr_ptr_r;
    rd_next_s   = rd_ptr_r;
    cnt_next_s  = count_r;
    head_next_s = '0;
    if (state_r != ST_EMPTY) begin
      pop_s = rdy;
    end else begin
      pop_s = 1'b0;
    end
    if (push) begin
      wr_next_s = wr_ptr_r + 1'b1;
    end else begin
      wr_next_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_next_s = rd_ptr_r + 1'b1;
    end else begin
      rd_next_s = rd_ptr_r;
    end
    cnt_next_s = count_r + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop_s};
    // A push landing on the new read slot becomes the head straight away.
    if (cnt_next_s == {(AW+1){1'b0}}) begin
      head_next_s = '0;
    end else if (push && (rd_next_s == wr_ptr_r)) begin
      head_next_s = data;
    end else begin
      head_next_s = mem_r[rd_next_s];
    end
  end

  // Channel state machine, storage and registered head/flag outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_EMPTY;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      head_r   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      wr_ptr_r <= wr_next_s;
      rd_ptr_r <= rd_next_s;
      count_r  <= cnt_next_s;
      head_r   <= head_next_s;
      if (push) begin
        mem_r[wr_ptr_r] <= data;
      end
      case (state_r)
        ST_EMPTY, ST_PART, ST_FULL: begin
          if (cnt_next_s == {(AW+1){1'b0}}) begin
            state_r <= ST_EMPTY;
          end else if (cnt_next_s == FULL_CNT) begin
            state_r <= ST_FULL;
          end else begin
            state_r <= ST_PART;
          end
        end
        default: state_r <= ST_EMPTY;
      endcase
    end
  end

  assign head  = head_r;
  assign valid = (state_r != ST_EMPTY);
  assign full  = (state_r == ST_FULL);

endmodule

module demux_two #(
  parameter int W     = 4,
  parameter int DEPTH = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] Y,
  input  logic         S,
  input  logic         E,
  output logic         ACC,
  output logic [W-1:0] A,
  output logic         A_V,
  input  logic         A_RDY,
  output logic [W-1:0] B,
  output logic         B_V,
  input  logic         B_RDY,
  output logic         FULL_A,
  output logic         FULL_B
`ifdef DEMUX_TWO_DROP_CNT_EN
  ,
  output logic [7:0]   DROPS
`endif
);

  logic full_a_s;
  logic full_b_s;
  logic full_sel_s;
  logic acc_s;
  logic push_a_s;
  logic push_b_s;

  // Acceptance uses the start-of-cycle full flag, so a same-cycle pop never rescues a push.
  always_comb begin
    full_sel_s = 1'b0;
    acc_s      = 1'b0;
    if (S) begin
      full_sel_s = full_b_s;
    end else begin
      full_sel_s = full_a_s;
    end
    if (RST) begin
      acc_s = 1'b0;
    end else begin
      acc_s = ~E & ~full_sel_s;
    end
  end

  assign push_a_s = acc_s & ~S;
  assign push_b_s = acc_s & S;
  assign ACC      = acc_s;
  assign FULL_A   = full_a_s;
  assign FULL_B   = full_b_s;

  demux_two_chan #(.W(W), .DEPTH(DEPTH)) u_chan_a (
    .clk   (CLK),
    .rst   (RST),
    .push  (push_a_s),
    .data  (Y),
    .rdy   (A_RDY),
    .head  (A),
    .valid (A_V),
    .full  (full_a_s)
  );

  demux_two_chan #(.W(W), .DEPTH(DEPTH)) u_chan_b (
    .clk   (CLK),
    .rst   (RST),
    .push  (push_b_s),
    .data  (Y),
    .rdy   (B_RDY),
    .head  (B),
    .valid (B_V),
    .full  (full_b_s)
  );

`ifdef DEMUX_TWO_DROP_CNT_EN
  logic [7:0] drops_r;

  // Saturating count of valid words refused because their channel was full.
  always_ff @(posedge CLK) begin
    if (RST) begin
      drops_r <= 8'd0;
    end else if (~E & full_sel_s & (drops_r != 8'hFF)) begin
      drops_r <= drops_r + 8'd1;
    end else begin
      drops_r <= drops_r;
    end
  end

  assign DROPS = drops_r;
`endif

endmodule

// File: tb/tb_demux_two.sv
// Randomised self-checking bench for demux_two; reference model keeps each channel
// as a plain queue and derives acceptance from queue occupancy.

module tb_demux_two;

  localparam int DEPTH = 2;

  logic       CLK;
  logic       RST;
  logic [3:0] Y;
  logic       S;
  logic       E;
  logic       ACC;
  logic [3:0] A;
  logic       A_V;
  logic       A_RDY;
  logic [3:0] B;
  logic       B_V;
  logic       B_RDY;
  logic       FULL_A;
  logic       FULL_B;
`ifdef DEMUX_TWO_DROP_CNT_EN
  logic [7:0] DROPS;
`endif

  demux_two #(.W(4), .DEPTH(DEPTH)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .Y      (Y),
    .S      (S),
    .E      (E),
    .ACC    (ACC),
    .A      (A),
    .A_V    (A_V),
    .A_RDY  (A_RDY),
    .B      (B),
    .B_V    (B_V),
    .B_RDY  (B_RDY),
    .FULL_A (FULL_A),
    .FULL_B (FULL_B)
`ifdef DEMUX_TWO_DROP_CNT_EN
    ,
    .DROPS  (DROPS)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [3:0] qa[$];
  logic [3:0] qb[$];
  int         drops_m;
  int         n_pass;
  int         n_total;
  logic       acc_obs;
  logic       acc_exp;

  function automatic logic [11:0] exp_outs();
    logic [3:0] ha;
    logic [3:0] hb;
    ha = (qa.size() != 0) ? qa[0] : 4'h0;
    hb = (qb.size() != 0) ? qb[0] : 4'h0;
    return {qa.size() != 0, ha, qb.size() != 0, hb,
            qa.size() == DEPTH, qb.size() == DEPTH};
  endfunction

  function automatic logic [11:0] obs_outs();
    return {A_V, A, B_V, B, FULL_A, FULL_B};
  endfunction

  // One bus cycle: drive at negedge, capture ACC, advance model at posedge, return at negedge.
  task automatic step(input logic [3:0] y, input logic s, input logic e,
                      input logic ardy, input logic brdy);
    logic room;
    Y = y; S = s; E = e; A_RDY = ardy; B_RDY = brdy;
    #1;
    acc_obs = ACC;
    room    = s ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
    acc_exp = !RST && !e && room;
    @(posedge CLK);
    if (RST) begin
      qa.delete(); qb.delete(); drops_m = 0;
    end else begin
      if (ardy && qa.size() > 0) void'(qa.pop_front());
      if (brdy && qb.size() > 0) void'(qb.pop_front());
      if (acc_exp) begin
        if (s) qb.push_back(y); else qa.push_back(y);
      end else if (!e && drops_m < 255) begin
        drops_m++;
      end
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step(4'($urandom), 1'($urandom), 1'b0, 1'b1, 1'b1);
    n_total++;
    if (acc_obs !== 1'b0) $display("FAIL reset_acc actual=%b required=0", acc_obs);
    else n_pass++;
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(4'($urandom), 1'($urandom), 1'b1, 1'($urandom), 1'($urandom));
      n_total++;
      if (acc_obs !== 1'b0 || obs_outs() !== 12'h000)
        $display("FAIL reset_idle cyc=%0d actual acc=%b outs=%h required acc=0 outs=000",
                 i, acc_obs, obs_outs());
      else n_pass++;
    end
  endtask

  task automatic test_single_push();
    step(4'hA, 1'b0, 1'b0, 1'b1, 1'b1);
    n_total++;
    if (acc_obs !== 1'b1 || A !== 4'hA || A_V !== 1'b1 || B_V !== 1'b0)
      $display("FAIL single_push actual acc=%b A=%h A_V=%b B_V=%b required 1 a 1 0",
               acc_obs, A, A_V, B_V);
    else n_pass++;
    step(4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    n_total++;
    if (A_V !== 1'b0 || A !== 4'h0 || B_V !== 1'b0)
      $display("FAIL single_drain actual A_V=%b A=%h B_V=%b required 0 0 0", A_V, A, B_V);
    else n_pass++;
  endtask

  task automatic test_fill_drop();
    logic [3:0] words [3];
    logic       accs  [3];
    int         d0;
    words = '{4'h1, 4'h2, 4'h3};
    accs  = '{1'b1, 1'b1, 1'b0};
    d0    = drops_m;
    for (int i = 0; i < 3; i++) begin
      step(words[i], 1'b0, 1'b0, 1'b0, 1'b1);
      n_total++;
      if (acc_obs !== accs[i] || FULL_A !== (i >= 1))
        $display("FAIL fill_acc word=%0d actual acc=%b full=%b required acc=%b full=%b",
                 i, acc_obs, FULL_A, accs[i], (i >= 1));
      else n_pass++;
    end
    n_total++;
    if (A !== 4'h1 || obs_outs() !== exp_outs())
      $display("FAIL fill_head actual=%h required=%h", obs_outs(), exp_outs());
    else n_pass++;
    step(4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    n_total++;
    if (A !== 4'h2 || A_V !== 1'b1 || FULL_A !== 1'b0)
      $display("FAIL drain_second actual A=%h A_V=%b FULL_A=%b required 2 1 0", A, A_V, FULL_A);
    else n_pass++;
    step(4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    n_total++;
    if (A_V !== 1'b0 || A !== 4'h0)
      $display("FAIL drain_empty actual A=%h A_V=%b required 0 0", A, A_V);
    else n_pass++;
`ifdef DEMUX_TWO_DROP_CNT_EN
    n_total++;
    if (int'(DROPS) !== d0 + 1) $display("FAIL fill_drops actual=%0d required=%0d", DROPS, d0 + 1);
    else n_pass++;
`endif
  endtask

  task automatic test_alternate();
    logic [3:0] got_a[$];
    logic [3:0] got_b[$];
    int         d0;
    d0 = drops_m;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) step(4'(i), 1'(i % 2), 1'b0, 1'b1, 1'b1);
      else       step(4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
      if (A_V) got_a.push_back(A);
      if (B_V) got_b.push_back(B);
    end
    n_total++;
    if (got_a != '{4'h0, 4'h2, 4'h4, 4'h6} || got_b != '{4'h1, 4'h3, 4'h5, 4'h7} || drops_m != d0)
      $display("FAIL alternate actual a=%p b=%p required a=0,2,4,6 b=1,3,5,7", got_a, got_b);
    else n_pass++;
  endtask

  task automatic test_full_pop_push();
    step(4'h5, 1'b1, 1'b0, 1'b1, 1'b0);
    step(4'h6, 1'b1, 1'b0, 1'b1, 1'b0);
    n_total++;
    if (FULL_B !== 1'b1) $display("FAIL b_full actual=%b required=1", FULL_B);
    else n_pass++;
    step(4'h7, 1'b1, 1'b0, 1'b1, 1'b1);
    n_total++;
    if (acc_obs !== 1'b0 || FULL_B !== 1'b0 || B !== 4'h6 || B_V !== 1'b1)
      $display("FAIL full_pop_push actual acc=%b FULL_B=%b B=%h required 0 0 6", acc_obs, FULL_B, B);
    else n_pass++;
    step(4'h9, 1'b0, 1'b0, 1'b1, 1'b1);
    n_total++;
    if (acc_obs !== 1'b1 || A !== 4'h9 || B_V !== 1'b0)
      $display("FAIL cross_chan actual acc=%b A=%h B_V=%b required 1 9 0", acc_obs, A, B_V);
    else n_pass++;
    step(4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom), 1'($urandom), ($urandom_range(0, 9) > 6), 1'($urandom), 1'($urandom));
      n_total++;
      if (acc_obs !== acc_exp || obs_outs() !== exp_outs())
        $display("FAIL random cyc=%0d actual acc=%b outs=%h required acc=%b outs=%h",
                 i, acc_obs, obs_outs(), acc_exp, exp_outs());
      else n_pass++;
`ifdef DEMUX_TWO_DROP_CNT_EN
      n_total++;
      if (int'(DROPS) !== drops_m) $display("FAIL random_drops actual=%0d required=%0d", DROPS, drops_m);
      else n_pass++;
`endif
    end
  endtask

  task automatic test_reset_midflight();
    step(4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'hC, 1'b1, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (obs_outs() !== exp_outs() || A_V !== 1'b1 || B_V !== 1'b1)
      $display("FAIL preload actual=%h required=%h", obs_outs(), exp_outs());
    else n_pass++;
    RST = 1'b1;
    step(4'hF, 1'b0, 1'b0, 1'b1, 1'b1);
    RST = 1'b0;
    n_total++;
    if (obs_outs() !== 12'h000 || acc_obs !== 1'b0)
      $display("FAIL reset_flush actual acc=%b outs=%h required acc=0 outs=000", acc_obs, obs_outs());
    else n_pass++;
`ifdef DEMUX_TWO_DROP_CNT_EN
    n_total++;
    if (DROPS !== 8'd0) $display("FAIL reset_drops actual=%0d required=0", DROPS);
    else n_pass++;
`endif
  endtask

  initial begin
    n_pass = 0; n_total = 0; drops_m = 0;
    RST = 1'b1; Y = 4'h0; S = 1'b0; E = 1'b1; A_RDY = 1'b0; B_RDY = 1'b0;
    @(negedge CLK);
    test_reset();
    test_single_push();
    test_fill_drop();
    test_alternate();
    test_full_pop_push();
    test_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
